// File: rtl/axi_lite_pkg.sv
// Shared definitions for the s3_axi family of AXI4-Lite slaves:
// response codes, write-FSM state type and the write response decode.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    // Decode wins over access mode: an unmapped index is DECERR even if RO.
    function automatic logic [1:0] wr_resp_code(input logic in_range, input logic ro);
        if (!in_range) return RESP_DECERR;
        if (ro)        return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite write channel controller: independent AW/W slots, commit decode,
// write FSM and B-channel response. Emits a one-cycle commit to the register array.
module axi_lite_wr_ctrl #(
    parameter int                DATA_WIDTH = 32,
    parameter int                ADDR_WIDTH = 8,
    parameter int                RESP_WIDTH = 2,
    parameter int                NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [RESP_WIDTH-1:0]   o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_wr_en,
    output logic [ADDR_WIDTH-3:0]   o_wr_idx,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_wr_strb
);
    import axi_lite_pkg::*;

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    wr_state_t           r_state;
    wr_state_t           w_next;
    logic                r_aw_held;
    logic                r_w_held;
    logic [IDX_W-1:0]    r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [RESP_WIDTH-1:0] r_bresp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_commit;
    logic w_in_range;
    logic w_ro;
    logic w_unused_addr;

    assign w_unused_addr = &{1'b0, i_awaddr[1:0]};

    assign o_awready = !r_aw_held && !o_bvalid;
    assign o_wready  = !r_w_held && !o_bvalid;
    assign w_aw_hs   = i_awvalid && o_awready;
    assign w_w_hs    = i_wvalid && o_wready;

    always_comb begin
        w_in_range = (32'(r_aw_idx) < NUM_REGS);
        w_ro       = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(r_aw_idx) == i) w_ro = RO_MASK[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= WR_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WR_IDLE: if (r_aw_held && r_w_held) w_next = WR_RESP;
            WR_RESP: if (i_bready)              w_next = WR_IDLE;
            default:                            w_next = WR_IDLE;
        endcase
    end

    always_comb begin
        o_bvalid = (r_state == WR_RESP);
        w_commit = (r_state == WR_IDLE) && r_aw_held && r_w_held;
        o_wr_en  = w_commit && w_in_range && !w_ro;
    end

    // Slots are freed on commit; bvalid then keeps the readies low until B completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= i_awaddr[ADDR_WIDTH-1:2];
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end
            if (w_commit) r_bresp <= RESP_WIDTH'(wr_resp_code(w_in_range, w_ro));
        end
    end

    assign o_bresp   = r_bresp;
    assign o_wr_idx  = r_aw_idx;
    assign o_wr_data = r_wdata;
    assign o_wr_strb = r_wstrb;

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite register bank: RW registers exposed in parallel on reg_out,
// RO registers read from status_in, write commits strobed on wr_pulse.
module axi_lite_regbank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  RESP_WIDTH = 2,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           s3_axi_aclk,
    input  logic                           s3_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s3_axi_awaddr,
    input  logic                           s3_axi_awvalid,
    output logic                           s3_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s3_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s3_axi_wstrb,
    input  logic                           s3_axi_wvalid,
    output logic                           s3_axi_wready,
    output logic [RESP_WIDTH-1:0]          s3_axi_bresp,
    output logic                           s3_axi_bvalid,
    input  logic                           s3_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s3_axi_araddr,
    input  logic                           s3_axi_arvalid,
    output logic                           s3_axi_arready,
    output logic [DATA_WIDTH-1:0]          s3_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s3_axi_rresp,
    output logic                           s3_axi_rvalid,
    input  logic                           s3_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    import axi_lite_pkg::*;

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0]                 r_wr_pulse;

    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;

    axi_lite_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESP_WIDTH (RESP_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_wr_ctrl (
        .i_clk     (s3_axi_aclk),
        .i_rst     (s3_axi_areset),
        .i_awaddr  (s3_axi_awaddr),
        .i_awvalid (s3_axi_awvalid),
        .o_awready (s3_axi_awready),
        .i_wdata   (s3_axi_wdata),
        .i_wstrb   (s3_axi_wstrb),
        .i_wvalid  (s3_axi_wvalid),
        .o_wready  (s3_axi_wready),
        .o_bresp   (s3_axi_bresp),
        .o_bvalid  (s3_axi_bvalid),
        .i_bready  (s3_axi_bready),
        .o_wr_en   (w_wr_en),
        .o_wr_idx  (w_wr_idx),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb)
    );

    always_ff @(posedge s3_axi_aclk) begin
        if (s3_axi_areset) begin
            r_regs     <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_en && (32'(w_wr_idx) == i)) begin
                    r_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign reg_out  = r_regs;
    assign wr_pulse = r_wr_pulse;

    // Read path: address slot, then registered response one edge later.
    logic                  r_ar_held;
    logic [IDX_W-1:0]      r_ar_idx;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [RESP_WIDTH-1:0] r_rresp;

    logic                  w_ar_hs;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused_araddr;

    assign w_unused_araddr = &{1'b0, s3_axi_araddr[1:0]};
    assign s3_axi_arready  = !r_ar_held && !r_rvalid;
    assign w_ar_hs         = s3_axi_arvalid && s3_axi_arready;

    always_comb begin
        w_rd_in_range = (32'(r_ar_idx) < NUM_REGS);
        w_rd_data     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(r_ar_idx) == i)
                w_rd_data = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
        end
    end

    always_ff @(posedge s3_axi_aclk) begin
        if (s3_axi_areset) begin
            r_ar_held <= 1'b0;
            r_ar_idx  <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
        end else begin
            if (r_ar_held) begin
                r_ar_held <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_in_range ? w_rd_data : '0;
                r_rresp   <= RESP_WIDTH'(w_rd_in_range ? RESP_OKAY : RESP_DECERR);
            end else if (r_rvalid && s3_axi_rready) begin
                r_rvalid  <= 1'b0;
            end
            if (w_ar_hs) begin
                r_ar_held <= 1'b1;
                r_ar_idx  <= s3_axi_araddr[ADDR_WIDTH-1:2];
            end
        end
    end

    assign s3_axi_rvalid = r_rvalid;
    assign s3_axi_rdata  = r_rdata;
    assign s3_axi_rresp  = r_rresp;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: AXI-Lite write/read tasks with response
// scoreboards and a shadow register model; register 3 is read-only.
module tb_axi_lite_regbank;

    localparam logic [15:0] RO = 16'h0008;

    logic         clk;
    logic         rst;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] reg_out;
    logic [511:0] status_in;
    logic [15:0]  wr_pulse;

    logic [15:0][31:0] model;
    logic [1:0]        bq[$];
    logic [31:0]       rdq[$];
    logic [1:0]        rrq[$];
    int total = 0;
    int bad   = 0;

    axi_lite_regbank #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESP_WIDTH (2),
        .NUM_REGS   (16),
        .RO_MASK    (RO)
    ) dut (
        .s3_axi_aclk    (clk),
        .s3_axi_areset  (rst),
        .s3_axi_awaddr  (awaddr),
        .s3_axi_awvalid (awvalid),
        .s3_axi_awready (awready),
        .s3_axi_wdata   (wdata),
        .s3_axi_wstrb   (wstrb),
        .s3_axi_wvalid  (wvalid),
        .s3_axi_wready  (wready),
        .s3_axi_bresp   (bresp),
        .s3_axi_bvalid  (bvalid),
        .s3_axi_bready  (bready),
        .s3_axi_araddr  (araddr),
        .s3_axi_arvalid (arvalid),
        .s3_axi_arready (arready),
        .s3_axi_rdata   (rdata),
        .s3_axi_rresp   (rresp),
        .s3_axi_rvalid  (rvalid),
        .s3_axi_rready  (rready),
        .reg_out        (reg_out),
        .status_in      (status_in),
        .wr_pulse       (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the last handshake.
    task automatic send(input bit da, input bit dw, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bit ah, wh;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = da; wvalid = dw;
        while ((awvalid || wvalid) && n < 50) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(negedge clk);
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
            n++;
        end
        check("hs_timeout", {awvalid, wvalid}, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // lead < 0: AW and W together; else W first, AW after 'lead' idle cycles.
    task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int lead, input int stall);
        int idx = int'(a[7:2]);
        logic [1:0]  er;
        logic [15:0] ep = '0;
        if (idx >= 16)   er = 2'd3;
        else if (RO[idx]) er = 2'd2;
        else             er = 2'd0;
        if (er == 2'd0) begin
            ep[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        end
        bq.push_back(er);
        if (lead < 0) send(1, 1, a, d, s);
        else begin
            send(0, 1, a, d, s);
            for (int k = 0; k < lead; k++) begin
                @(negedge clk);
                check("w_held_wready", wready, 1'b0);
                check("w_held_awready", awready, 1'b1);
            end
            send(1, 0, a, d, s);
        end
        check("b_early", bvalid, 1'b0);
        @(negedge clk);
        check("bvalid", bvalid, 1'b1);
        check("wr_pulse", wr_pulse, ep);
        check("reg_out", reg_out, model);
        @(negedge clk);
        check("wr_pulse_clr", wr_pulse, 16'h0);
        check("bvalid_hold", bvalid, 1'b1);
        for (int k = 0; k < stall; k++) begin
            check("b_stall_awready", awready, 1'b0);
            check("b_stall_wready", wready, 1'b0);
            check("b_stall_bvalid", bvalid, 1'b1);
            check("b_stall_bresp", bresp, bq[0]);
            @(negedge clk);
        end
        bready = 1'b1;
        check("bresp", bresp, bq.pop_front());
        @(negedge clk);
        bready = 1'b0;
        check("b_done", bvalid, 1'b0);
        check("awready_back", awready, 1'b1);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er,
                      input int stall);
        int n = 0;
        rdq.push_back(ed);
        rrq.push_back(er);
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_timeout", 1'(n < 50), 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_early", rvalid, 1'b0);
        check("arready_busy", arready, 1'b0);
        @(negedge clk);
        check("rvalid", rvalid, 1'b1);
        for (int k = 0; k < stall; k++) begin
            check("r_stall_rvalid", rvalid, 1'b1);
            check("r_stall_rdata", rdata, rdq[0]);
            check("r_stall_arready", arready, 1'b0);
            @(negedge clk);
        end
        rready = 1'b1;
        check("rdata", rdata, rdq.pop_front());
        check("rresp", rresp, rrq.pop_front());
        @(negedge clk);
        rready = 1'b0;
        check("r_done", rvalid, 1'b0);
        check("arready_back", arready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        status_in = '0;
        status_in[3*32 +: 32] = 32'h0000_DEAD;
        status_in[2*32 +: 32] = 32'hFFFF_FFFF;
        model = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bresp", bresp, 2'd0);
        check("rst_rresp", rresp, 2'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wr_pulse", wr_pulse, 16'h0);
        check("rst_reg_out", reg_out, 512'h0);
        check("rst_readies", {awready, wready, arready}, 3'b111);

        // same-cycle AW/W, then W leading AW with B backpressure
        write(8'h00, 32'd25, 4'hF, -1, 0);
        write(8'h04, 32'd34, 4'hF, 3, 5);

        // byte strobes, RW register ignores status_in
        write(8'h08, 32'hAABB_CCDD, 4'hF, -1, 0);
        write(8'h08, 32'h1122_3344, 4'h5, -1, 2);
        rd(8'h08, 32'hAA22_CC44, 2'd0, 0);
        rd(8'h00, 32'd25, 2'd0, 3);
        rd(8'h07, 32'd34, 2'd0, 0);

        // zero strobe still pulses
        write(8'h00, 32'hFFFF_FFFF, 4'h0, -1, 0);

        // read-only register
        write(8'h0C, 32'h1234_5678, 4'hF, -1, 1);
        rd(8'h0C, 32'h0000_DEAD, 2'd0, 0);

        // out of range
        write(8'h40, 32'h5555_5555, 4'hF, 2, 0);
        rd(8'h40, 32'h0, 2'd3, 1);

        // reset with only AW held: W alone afterwards must not commit
        send(1, 0, 8'h14, 32'h0, 4'h0);
        check("aw_held_awready", awready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model = '0;
        check("mid_rst_readies", {awready, wready, arready}, 3'b111);
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_reg_out", reg_out, model);
        send(0, 1, 8'h00, 32'h0000_0077, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("orphan_w_bvalid", bvalid, 1'b0);
            check("orphan_w_pulse", wr_pulse, 16'h0);
            check("orphan_w_awready", awready, 1'b1);
            check("orphan_w_reg_out", reg_out, model);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
